// File: rtl/accumulator_unit.sv
// Accumulator with LOAD/ADD/SUB/NOP, IDLE->EXEC->DONE handshake and flags.
// Define ACC_SATURATE_EN to clamp ADD/SUB on signed overflow instead of wrapping.
module accumulator_unit #(
  parameter int DB = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DB-1:0] Operando,
  input  logic [1:0]    Op,
  input  logic          OpValido,
  input  logic          Limpiar,
  output logic          Listo,
  output logic [DB-1:0] Acc,
  output logic          ResValido,
  output logic          Zero,
  output logic          Carry,
  output logic          Desborde
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  localparam logic [DB-1:0] MAXP = {1'b0, {(DB-1){1'b1}}};
  localparam logic [DB-1:0] MINN = {1'b1, {(DB-1){1'b0}}};

  state_t        state;
  state_t        state_nx;
  logic [DB-1:0] opnd_q;
  logic [1:0]    op_q;
  logic          accept;
  logic          op_load;
  logic          op_add;
  logic          op_sub;
  logic          op_nop;
  logic [DB:0]   sum;
  logic [DB:0]   dif;
  logic [DB-1:0] acc_nx;
  logic          carry_nx;
  logic          ovf_nx;

  assign Listo     = (state == IDLE);
  assign ResValido = (state == DONE);
  assign accept    = Listo & OpValido & ~Limpiar;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (OpValido) state_nx = EXEC;
      EXEC:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (Limpiar) state_nx = IDLE;
  end

  assign op_load = (op_q == 2'b00);
  assign op_add  = (op_q == 2'b01);
  assign op_sub  = (op_q == 2'b10);
  assign op_nop  = (op_q == 2'b11);

  assign sum = {1'b0, Acc} + {1'b0, opnd_q};
  assign dif = {1'b0, Acc} - {1'b0, opnd_q};

  always_comb begin
    acc_nx   = Acc;
    carry_nx = Carry;
    ovf_nx   = Desborde;
    unique case (1'b1)
      op_load: begin
        acc_nx   = opnd_q;
        carry_nx = 1'b0;
        ovf_nx   = 1'b0;
      end
      op_add: begin
        acc_nx   = sum[DB-1:0];
        carry_nx = sum[DB];
        ovf_nx   = (Acc[DB-1] == opnd_q[DB-1]) &&
                   (sum[DB-1] != Acc[DB-1]);
      end
      op_sub: begin
        acc_nx   = dif[DB-1:0];
        carry_nx = dif[DB];
        ovf_nx   = (Acc[DB-1] != opnd_q[DB-1]) &&
                   (dif[DB-1] != Acc[DB-1]);
      end
      op_nop: ;
      default: ;
    endcase
`ifdef ACC_SATURATE_EN
    // overflow direction always follows the sign of the old Acc
    if ((op_add || op_sub) && ovf_nx)
      acc_nx = Acc[DB-1] ? MINN : MAXP;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Acc      <= '0;
      Zero     <= 1'b1;
      Carry    <= 1'b0;
      Desborde <= 1'b0;
      opnd_q   <= '0;
      op_q     <= 2'b11;
    end else if (Limpiar) begin
      Acc      <= '0;
      Zero     <= 1'b1;
      Carry    <= 1'b0;
      Desborde <= 1'b0;
    end else begin
      if (accept) begin
        opnd_q <= Operando;
        op_q   <= Op;
      end
      if (state == EXEC) begin
        Acc      <= acc_nx;
        Zero     <= (acc_nx == '0);
        Carry    <= carry_nx;
        Desborde <= ovf_nx;
      end
    end
  end

  wire unused_min = ^MINN ^ ^MAXP;

endmodule

// File: tb/tb_accumulator_unit.sv
// Self-checking bench for accumulator_unit (DB=16): transaction model
// checked every cycle plus directed literal expectations.
module tb_accumulator_unit;

  localparam int    DB   = 16;
  localparam longint MOD  = 64'd1 << DB;
  localparam longint HALF = 64'd1 << (DB - 1);
  localparam longint MAXS = HALF - 1;
  localparam longint MINS = -HALF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DB-1:0] Operando = '0;
  logic [1:0]    Op = 2'b11;
  logic          OpValido = 1'b0;
  logic          Limpiar = 1'b0;
  logic          Listo;
  logic [DB-1:0] Acc;
  logic          ResValido;
  logic          Zero;
  logic          Carry;
  logic          Desborde;

  int compared = 0;
  int mismatched = 0;

  accumulator_unit #(.DB(DB)) dut (
    .clk(clk), .rst_n(rst_n), .Operando(Operando), .Op(Op),
    .OpValido(OpValido), .Limpiar(Limpiar), .Listo(Listo), .Acc(Acc),
    .ResValido(ResValido), .Zero(Zero), .Carry(Carry), .Desborde(Desborde)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: busy counts cycles left before ready again.
  longint     m_acc = 0;
  bit         m_c = 1'b0;
  bit         m_v = 1'b0;
  int         busy = 0;
  logic [1:0] p_op = 2'b11;
  longint     p_b = 0;

  function automatic longint sgn(input longint u);
    return (u >= HALF) ? u - MOD : u;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    longint ss, res;
    if (!rst_n) begin
      m_acc = 0; m_c = 0; m_v = 0; busy = 0;
    end else if (Limpiar) begin
      m_acc = 0; m_c = 0; m_v = 0; busy = 0;
    end else if (busy == 0) begin
      if (OpValido) begin
        p_op = Op; p_b = longint'(Operando); busy = 2;
      end
    end else if (busy == 2) begin
      busy = 1;
      ss = 0;
      res = m_acc;
      case (p_op)
        2'b00: begin res = p_b; m_c = 0; m_v = 0; end
        2'b01: begin
          m_c = (m_acc + p_b) >= MOD;
          ss  = sgn(m_acc) + sgn(p_b);
          m_v = (ss > MAXS) || (ss < MINS);
          res = (m_acc + p_b) % MOD;
        end
        2'b10: begin
          m_c = m_acc < p_b;
          ss  = sgn(m_acc) - sgn(p_b);
          m_v = (ss > MAXS) || (ss < MINS);
          res = (m_acc - p_b + MOD) % MOD;
        end
        default: ;
      endcase
`ifdef ACC_SATURATE_EN
      if (p_op != 2'b11 && p_op != 2'b00 && m_v)
        res = (ss > MAXS) ? MAXS : MINS + MOD;
`endif
      m_acc = res;
    end else begin
      busy = 0;
    end
  end

  bit run = 1'b0;

  always @(negedge clk) begin
    if (run) begin
      chk("m_acc", 32'(Acc), 32'(m_acc));
      chk("m_zero", 32'(Zero), 32'(m_acc == 0));
      chk("m_carry", 32'(Carry), 32'(m_c));
      chk("m_ovf", 32'(Desborde), 32'(m_v));
      chk("m_listo", 32'(Listo), 32'(busy == 0));
      chk("m_resval", 32'(ResValido), 32'(busy == 1));
    end
  end

  task automatic do_op(input logic [1:0] op, input logic [DB-1:0] d);
    int n = 0;
    int rv = 0;
    int bz = 0;
    while (!Listo && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("listo_timeout", 32'(Listo), 32'd1);
    Op = op; Operando = d; OpValido = 1'b1;
    @(negedge clk);
    OpValido = 1'b0; Operando = ~d; Op = ~op;
    rv += int'(ResValido); bz += int'(!Listo);
    repeat (2) begin
      @(negedge clk);
      rv += int'(ResValido); bz += int'(!Listo);
    end
    chk("rv_pulses", 32'(rv), 32'd1);
    chk("busy_cycles", 32'(bz), 32'd2);
  endtask

  initial begin
    int acc_cnt;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_acc", 32'(Acc), 32'h0);
    chk("rst_zero", 32'(Zero), 32'd1);
    chk("rst_listo", 32'(Listo), 32'd1);
    chk("rst_resval", 32'(ResValido), 32'd0);
    chk("rst_cv", 32'({Carry, Desborde}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b1;

    do_op(2'b00, 16'h1234);
    chk("load_acc", 32'(Acc), 32'h1234);
    chk("load_zero", 32'(Zero), 32'd0);

    do_op(2'b00, 16'h7FFF);
    do_op(2'b01, 16'h0001);
`ifdef ACC_SATURATE_EN
    chk("add_ovf_acc", 32'(Acc), 32'h7FFF);
`else
    chk("add_ovf_acc", 32'(Acc), 32'h8000);
`endif
    chk("add_ovf_v", 32'(Desborde), 32'd1);
    chk("add_ovf_c", 32'(Carry), 32'd0);

    do_op(2'b00, 16'h0005);
    do_op(2'b10, 16'h0005);
    chk("sub_eq_acc", 32'(Acc), 32'h0);
    chk("sub_eq_zc", 32'({Zero, Carry}), 32'b10);
    do_op(2'b10, 16'h0001);
    chk("sub_brw_acc", 32'(Acc), 32'hFFFF);
    chk("sub_brw_cv", 32'({Carry, Desborde}), 32'b10);

    do_op(2'b11, 16'h5555);
    chk("nop_acc", 32'(Acc), 32'hFFFF);
    chk("nop_c", 32'(Carry), 32'd1);

    do_op(2'b01, 16'h0001);
    chk("add_wrap0", 32'({Acc, Zero, Carry, Desborde}), 32'h0000_0006);

    do_op(2'b00, 16'h8000);
    do_op(2'b10, 16'h0001);
`ifdef ACC_SATURATE_EN
    chk("sub_ovf_acc", 32'(Acc), 32'h8000);
`else
    chk("sub_ovf_acc", 32'(Acc), 32'h7FFF);
`endif
    chk("sub_ovf_v", 32'(Desborde), 32'd1);

    do_op(2'b00, 16'h0000);
    acc_cnt = 0;
    Op = 2'b01;
    for (int i = 0; i < 9; i++) begin
      Operando = (i % 2 == 0) ? 16'h0011 : 16'h0022;
      OpValido = 1'b1;
      if (Listo) acc_cnt++;
      @(negedge clk);
    end
    OpValido = 1'b0;
    chk("stream_accepts", 32'(acc_cnt), 32'd3);
    chk("stream_acc", 32'(Acc), 32'h0044);

    do_op(2'b00, 16'h0100);
    Op = 2'b01; Operando = 16'h0010; OpValido = 1'b1;
    @(negedge clk);
    Limpiar = 1'b1;
    @(negedge clk);
    chk("clr_acc", 32'(Acc), 32'h0);
    chk("clr_flags", 32'({Zero, Carry, Desborde}), 32'b100);
    chk("clr_idle", 32'({Listo, ResValido}), 32'b10);
    @(negedge clk);
    Limpiar = 1'b0; OpValido = 1'b0;
    @(negedge clk);
    chk("clr_noacc", 32'({Listo, ResValido}), 32'b10);

    do_op(2'b00, 16'h0055);
    Op = 2'b01; Operando = 16'h0003; OpValido = 1'b1;
    @(negedge clk);
    OpValido = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_acc", 32'(Acc), 32'h0);
    chk("arst_state", 32'({Listo, ResValido, Zero}), 32'b101);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2'b00, 16'h00AA);
    chk("post_rst_acc", 32'(Acc), 32'h00AA);

    repeat (2) @(negedge clk);
    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
